inst_fifo: RTL and testbench

//  Instruction queue between the IF1 stage register and decode. It is the consumer end of the

---
 rtl/inst_fifo_if.sv | 45 ++++
 rtl/inst_fifo.sv | 109 ++++++++++
 tb/tb_inst_fifo.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_fifo_if.sv
// Handshake and data bundle between the IF1 stage register, the
// instruction queue and decode.
interface inst_fifo_if;
    // upstream packet side
    logic        fifo_readygo;
    logic        fifo_allowin;
    logic [31:0] in_pc;
    logic [31:0] in_pc_next;
    logic [31:0] in_inst0;
    logic [31:0] in_inst1;
    logic [31:0] in_badv;
    logic [6:0]  in_exception;
    logic [1:0]  in_excp_flag;
    // decode side
    logic        id_allowin;
    logic        out_valid0;
    logic        out_valid1;
    logic [31:0] out_pc0;
    logic [31:0] out_pc1;
    logic [31:0] out_pc_next0;
    logic [31:0] out_pc_next1;
    logic [31:0] out_inst0;
    logic [31:0] out_inst1;
    logic [31:0] out_badv0;
    logic [6:0]  out_exception0;
    logic [1:0]  out_excp_flag0;

    // the queue itself
    modport slave (
        input  fifo_readygo, in_pc, in_pc_next, in_inst0, in_inst1,
               in_badv, in_exception, in_excp_flag, id_allowin,
        output fifo_allowin, out_valid0, out_valid1, out_pc0, out_pc1,
               out_pc_next0, out_pc_next1, out_inst0, out_inst1,
               out_badv0, out_exception0, out_excp_flag0
    );

    // fetch + decode environment
    modport master (
        output fifo_readygo, in_pc, in_pc_next, in_inst0, in_inst1,
               in_badv, in_exception, in_excp_flag, id_allowin,
        input  fifo_allowin, out_valid0, out_valid1, out_pc0, out_pc1,
               out_pc_next0, out_pc_next1, out_inst0, out_inst1,
               out_badv0, out_exception0, out_excp_flag0
    );
endinterface

// File: rtl/inst_fifo.sv
// Instruction queue between IF1 and decode. Splits 2-instruction fetch
// packets into per-instruction entries and presents up to two show-ahead
// entries per cycle; exception entries are always presented alone in lane 0.
module inst_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    inst_fifo_if.slave  bus
);

    localparam logic [PTR_W:0] CNT_ALLOW_MAX = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] CNT_DEPTH     = (PTR_W+1)'(DEPTH);

    // per-entry storage
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] pcn_mem   [DEPTH];
    logic [31:0] inst_mem  [DEPTH];
    logic [31:0] badv_mem  [DEPTH];
    logic [6:0]  exc_mem   [DEPTH];
    logic [1:0]  flag_mem  [DEPTH];

    logic [PTR_W-1:0] head, tail, head1, tail1;
    logic [PTR_W:0]   count;

    logic        lane0_v, lane1_v, has_excp, wr_two;
    logic        push, pop, valid0, valid1;
    logic [1:0]  push_n, pop_n;
    logic [31:0] lane1_pc, e0_pc, e0_pcn, e0_inst;

    assign head1 = head + PTR_W'(1);
    assign tail1 = tail + PTR_W'(1);

    // packet decode: which lanes become entries and what the first entry holds
    always_comb begin
        lane0_v  = ~bus.in_pc[2];
        lane1_v  = ~(lane0_v & (bus.in_pc_next == bus.in_pc + 32'd4));
        has_excp = |bus.in_excp_flag;
        // lane1 is always valid when lane0 is not, so a packet yields 1 or 2 entries
        wr_two   = lane0_v & lane1_v & ~has_excp;
        lane1_pc = {bus.in_pc[31:3], 3'b100};
        e0_pc    = lane0_v ? bus.in_pc    : lane1_pc;
        e0_inst  = lane0_v ? bus.in_inst0 : bus.in_inst1;
        e0_pcn   = wr_two  ? bus.in_pc + 32'd4 : bus.in_pc_next;
        push     = bus.fifo_readygo & bus.fifo_allowin & ~flush;
        push_n   = push ? (wr_two ? 2'd2 : 2'd1) : 2'd0;
        valid0   = (count != '0);
        valid1   = (count >= (PTR_W+1)'(2)) & (flag_mem[head] == 2'b00)
                   & (flag_mem[head1] == 2'b00);
        pop      = bus.id_allowin & ~flush;
        pop_n    = pop ? ({1'b0, valid0} + {1'b0, valid1}) : 2'd0;
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        end
    end

    // entry writes at tail / tail+1; contents need no reset, valids gate them
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= e0_pc;
            pcn_mem[tail]  <= e0_pcn;
            inst_mem[tail] <= e0_inst;
            badv_mem[tail] <= bus.in_badv;
            exc_mem[tail]  <= bus.in_exception;
            flag_mem[tail] <= bus.in_excp_flag;
            if (wr_two) begin
                pc_mem[tail1]   <= lane1_pc;
                pcn_mem[tail1]  <= bus.in_pc_next;
                inst_mem[tail1] <= bus.in_inst1;
                badv_mem[tail1] <= bus.in_badv;
                exc_mem[tail1]  <= bus.in_exception;
                flag_mem[tail1] <= bus.in_excp_flag;
            end
        end
    end

    assign bus.fifo_allowin   = (count <= CNT_ALLOW_MAX);
    assign bus.out_valid0     = valid0;
    assign bus.out_valid1     = valid1;
    assign bus.out_pc0        = valid0 ? pc_mem[head]   : '0;
    assign bus.out_pc_next0   = valid0 ? pcn_mem[head]  : '0;
    assign bus.out_inst0      = valid0 ? inst_mem[head] : '0;
    assign bus.out_badv0      = valid0 ? badv_mem[head] : '0;
    assign bus.out_exception0 = valid0 ? exc_mem[head]  : '0;
    assign bus.out_excp_flag0 = valid0 ? flag_mem[head] : '0;
    assign bus.out_pc1        = valid1 ? pc_mem[head1]   : '0;
    assign bus.out_pc_next1   = valid1 ? pcn_mem[head1]  : '0;
    assign bus.out_inst1      = valid1 ? inst_mem[head1] : '0;

    // occupancy can never exceed the storage size
    assert property (@(posedge clk) disable iff (rst) count <= CNT_DEPTH);

endmodule

// File: tb/tb_inst_fifo.sv
// Directed + short random bench for inst_fifo with a queue scoreboard of
// expected entries in presentation order.
module tb_inst_fifo;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcn;
        logic [31:0] inst;
        logic [31:0] badv;
        logic [6:0]  exc;
        logic [1:0]  flag;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    inst_fifo_if bus();

    inst_fifo #(.DEPTH(16), .PTR_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // compare all presented outputs against the scoreboard head
    task automatic check_outputs();
        logic ev0, ev1;
        ev0 = (sb.size() >= 1);
        ev1 = (sb.size() >= 2) && (sb[0].flag == 2'b00) && (sb[1].flag == 2'b00);
        chk("count",   32'(dut.count), 32'(sb.size()));
        chk("allowin", 32'(bus.fifo_allowin), 32'(sb.size() <= 14));
        chk("valid0",  32'(bus.out_valid0), 32'(ev0));
        chk("valid1",  32'(bus.out_valid1), 32'(ev1));
        if (ev0) begin
            chk("pc0",   bus.out_pc0,      sb[0].pc);
            chk("pcn0",  bus.out_pc_next0, sb[0].pcn);
            chk("inst0", bus.out_inst0,    sb[0].inst);
            chk("badv0", bus.out_badv0,    sb[0].badv);
            chk("exc0",  32'(bus.out_exception0), 32'(sb[0].exc));
            chk("flag0", 32'(bus.out_excp_flag0), 32'(sb[0].flag));
        end else begin
            chk("pc0_zero",   bus.out_pc0,   32'h0);
            chk("inst0_zero", bus.out_inst0, 32'h0);
        end
        if (ev1) begin
            chk("pc1",   bus.out_pc1,      sb[1].pc);
            chk("pcn1",  bus.out_pc_next1, sb[1].pcn);
            chk("inst1", bus.out_inst1,    sb[1].inst);
        end else begin
            chk("pc1_zero", bus.out_pc1, 32'h0);
        end
    endtask

    // one clock: drive, check show-ahead outputs, predict, advance the model
    task automatic cycle(input logic rg, input logic [31:0] pc, input logic [31:0] pcn,
                         input logic [31:0] i0, input logic [31:0] i1,
                         input logic [1:0] fl, input logic ida, input logic fls);
        ent_t ne[$];
        ent_t e;
        logic v0, v1, acc;
        int   npop;
        bus.fifo_readygo = rg;
        bus.in_pc        = pc;
        bus.in_pc_next   = pcn;
        bus.in_inst0     = i0;
        bus.in_inst1     = i1;
        bus.in_excp_flag = fl;
        bus.in_badv      = (fl != 2'b00) ? pc : 32'h0;
        bus.in_exception = (fl != 2'b00) ? 7'h08 : 7'h00;
        bus.id_allowin   = ida;
        flush            = fls;
        #1;
        check_outputs();
        npop = 0;
        if (ida && !fls && sb.size() >= 1) begin
            npop = 1;
            if (sb.size() >= 2 && sb[0].flag == 2'b00 && sb[1].flag == 2'b00) npop = 2;
        end
        acc = rg && !fls && (sb.size() <= 14);
        if (acc) begin
            v0 = ~pc[2];
            v1 = !(v0 && (pcn == pc + 32'd4));
            if (fl != 2'b00) begin
                if (v0) v1 = 1'b0;
            end
            e.badv = bus.in_badv;
            e.exc  = bus.in_exception;
            e.flag = fl;
            if (v0) begin
                e.pc = pc; e.inst = i0; e.pcn = v1 ? pc + 32'd4 : pcn;
                ne.push_back(e);
            end
            if (v1) begin
                e.pc = {pc[31:3], 3'b100}; e.inst = i1; e.pcn = pcn;
                ne.push_back(e);
            end
        end
        @(posedge clk);
        if (fls) sb.delete();
        else begin
            repeat (npop) void'(sb.pop_front());
            foreach (ne[k]) sb.push_back(ne[k]);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ida);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, ida, 1'b0);
    endtask

    initial begin
        logic [31:0] rpc, rpcn;
        logic [1:0]  rfl;
        rst = 1'b1;
        flush = 1'b0;
        bus.fifo_readygo = 1'b0;
        bus.in_pc = '0; bus.in_pc_next = '0; bus.in_inst0 = '0; bus.in_inst1 = '0;
        bus.in_badv = '0; bus.in_exception = '0; bus.in_excp_flag = '0;
        bus.id_allowin = 1'b0;
        #2;
        // reset state
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // full pair, then both lanes presented
        cycle(1'b1, 32'h1c000000, 32'h1c000008, 32'h11, 32'h22, 2'b00, 1'b0, 1'b0);
        idle(1'b1);
        // underflow attempt on empty
        idle(1'b1);

        // bit2 packet -> one entry; pc_next == pc+4 -> one entry
        cycle(1'b1, 32'h1c000004, 32'h1c000010, 32'h33, 32'h44, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 32'h1c000010, 32'h1c000014, 32'h55, 32'h66, 2'b00, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // exception packet behind one normal entry
        cycle(1'b1, 32'h1c000010, 32'h1c000014, 32'h77, 32'h88, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 32'h1c000020, 32'h1c000028, 32'h99, 32'haa, 2'b01, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // fill to 16 with decode stalled; extra offer is refused
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 32'h1c001000 + 32'(i * 8), 32'h1c001008 + 32'(i * 8),
                  32'h100 + 32'(i), 32'h200 + 32'(i), 2'b00, 1'b0, 1'b0);
        // pop while full: allowin stays low this cycle, reopens next
        cycle(1'b1, 32'h1c002000, 32'h1c002008, 32'h300, 32'h301, 2'b00, 1'b1, 1'b0);
        cycle(1'b1, 32'h1c002000, 32'h1c002008, 32'h300, 32'h301, 2'b00, 1'b0, 1'b0);

        // random push/pop traffic across pointer wrap
        for (int i = 0; i < 40; i++) begin
            rpc = $urandom & 32'hffff_fffc;
            case ($urandom_range(0, 2))
                0: rpcn = rpc + 32'd4;
                1: rpcn = {rpc[31:3], 3'b000} + 32'd8;
                default: rpcn = $urandom & 32'hffff_fffc;
            endcase
            rfl = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
            cycle(1'($urandom_range(0, 1)), rpc, rpcn, $urandom, $urandom, rfl,
                  ($urandom_range(0, 3) != 0), 1'b0);
        end
        for (int i = 0; i < 12; i++) idle(1'b1);

        // build count = 7, then flush with a concurrent push
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h1c003000 + 32'(i * 8), 32'h1c003008 + 32'(i * 8),
                  32'h400 + 32'(i), 32'h500 + 32'(i), 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 32'h1c003104, 32'h1c003200, 32'h600, 32'h601, 2'b00, 1'b0, 1'b0);
        chk("count7", 32'(dut.count), 32'd7);
        cycle(1'b1, 32'h1c004000, 32'h1c004008, 32'h700, 32'h701, 2'b00, 1'b1, 1'b1);
        idle(1'b0);

        // async reset mid-stream clears immediately
        cycle(1'b1, 32'h1c005000, 32'h1c005008, 32'h800, 32'h801, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 32'h1c005008, 32'h1c005010, 32'h802, 32'h803, 2'b00, 1'b0, 1'b0);
        bus.fifo_readygo = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_valid0",  32'(bus.out_valid0), 32'd0);
        chk("rst_allowin", 32'(bus.fifo_allowin), 32'd1);
        chk("rst_count",   32'(dut.count), 32'd0);
        sb.delete();
        #1;
        rst = 1'b0;
        @(negedge clk);
        idle(1'b1);
        cycle(1'b1, 32'h1c006000, 32'h1c006008, 32'h900, 32'h901, 2'b00, 1'b0, 1'b0);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
